// File: rtl/mul_arb.sv
// Two-requester front end for a shared 64x64 multiplier: round-robin grant,
// RV64M op decode with MULHSU/MULW fix-up, and a 2-stage valid/ready pipeline.

module mul (
    input  logic [63:0]  a,
    input  logic [63:0]  b,
    input  logic         sign,
    output logic [127:0] res
);
    logic [127:0] prod_s;
    logic [127:0] prod_u;

    assign prod_s = {{64{a[63]}}, a} * {{64{b[63]}}, b};
    assign prod_u = {64'b0, a} * {64'b0, b};
    assign res    = sign ? prod_s : prod_u;
endmodule

module mul_arb #(
    parameter int TAG_W   = 4,
    parameter int RR_INIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [63:0]      req0_a,
    input  logic [63:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [63:0]      req1_a,
    input  logic [63:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [63:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_src,
    output logic             resp_err
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // Ready never depends on the op code; stall propagates backwards from resp_ready.

    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [63:0]      s1_a;
    logic [63:0]      s1_b;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_src;
    logic             last_grant;

    logic             s2_adv;
    logic             s1_adv;
    logic             grant0;
    logic             grant1;
    logic             take;

    logic [63:0]      mul_a;
    logic [63:0]      mul_b;
    logic             mul_sign;
    logic [127:0]     mul_res;
    logic [63:0]      s1_data;
    logic             s1_err;

    assign s2_adv = !resp_valid || resp_ready;
    assign s1_adv = !s1_valid || s2_adv;

    // On a tie the requester that did not win the last handshake goes first.
    assign grant0 = s1_adv && req0_valid && (!req1_valid || last_grant);
    assign grant1 = s1_adv && req1_valid && (!req0_valid || !last_grant);
    assign take   = grant0 || grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_op      <= 3'b0;
            s1_a       <= 64'b0;
            s1_b       <= 64'b0;
            s1_tag     <= '0;
            s1_src     <= 1'b0;
            last_grant <= RR_INIT[0];
        end else begin
            if (s1_adv) begin
                s1_valid <= take;
            end
            if (take) begin
                s1_op      <= grant1 ? req1_op  : req0_op;
                s1_a       <= grant1 ? req1_a   : req0_a;
                s1_b       <= grant1 ? req1_b   : req0_b;
                s1_tag     <= grant1 ? req1_tag : req0_tag;
                s1_src     <= grant1;
                last_grant <= grant1;
            end
        end
    end

    always_comb begin
        mul_sign = 1'b0;
        mul_a    = s1_a;
        mul_b    = s1_b;
        case (s1_op)
            3'b001: mul_sign = 1'b1;
            3'b100: begin
                mul_a = {32'b0, s1_a[31:0]};
                mul_b = {32'b0, s1_b[31:0]};
            end
            default: ;
        endcase
    end

    mul u_mul (
        .a    (mul_a),
        .b    (mul_b),
        .sign (mul_sign),
        .res  (mul_res)
    );

    // MULHSU runs the multiplier unsigned; a negative rs1 over-counts by rs2 * 2^64.
    always_comb begin
        s1_data = 64'b0;
        s1_err  = 1'b0;
        case (s1_op)
            3'b000:          s1_data = mul_res[63:0];
            3'b001, 3'b011:  s1_data = mul_res[127:64];
            3'b010:          s1_data = mul_res[127:64] - (s1_a[63] ? s1_b : 64'b0);
            3'b100:          s1_data = {{32{mul_res[31]}}, mul_res[31:0]};
            default:         s1_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_data  <= 64'b0;
            resp_tag   <= '0;
            resp_src   <= 1'b0;
            resp_err   <= 1'b0;
        end else if (s2_adv) begin
            resp_valid <= s1_valid;
            resp_data  <= s1_data;
            resp_tag   <= s1_tag;
            resp_src   <= s1_src;
            resp_err   <= s1_err;
        end
    end
endmodule

// File: tb/tb_mul_arb.sv
// Directed and random checks of mul_arb against an arithmetic reference model
// and an in-order expected-response queue.

module tb_mul_arb;
    localparam int TAG_W = 4;

    logic             clk;
    logic             rst;
    logic             req0_valid, req0_ready;
    logic [2:0]       req0_op;
    logic [63:0]      req0_a, req0_b;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid, req1_ready;
    logic [2:0]       req1_op;
    logic [63:0]      req1_a, req1_b;
    logic [TAG_W-1:0] req1_tag;
    logic             resp_valid, resp_ready;
    logic [63:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_src, resp_err;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int resp_cnt = 0;

    // expected response record: {err, src, tag, data}
    logic [69:0] exp_q[$];
    int          grant_log[$];
    int          src_log[$];
    logic        prev_stall = 1'b0;
    logic [69:0] prev_snap;

    mul_arb #(.TAG_W(TAG_W), .RR_INIT(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .resp_src(resp_src), .resp_err(resp_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [69:0] got, input logic [69:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // reference: full-width two's-complement arithmetic, returns {err, data}
    function automatic logic [64:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  w;
        case (op)
            3'd0: begin p = {64'b0, a} * {64'b0, b}; return {1'b0, p[63:0]}; end
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return {1'b0, p[127:64]}; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'b0, b}; return {1'b0, p[127:64]}; end
            3'd3: begin p = {64'b0, a} * {64'b0, b}; return {1'b0, p[127:64]}; end
            3'd4: begin w = a[31:0] * b[31:0]; return {1'b0, {32{w[31]}}, w}; end
            default: return {1'b1, 64'b0};
        endcase
    endfunction

    // scoreboard / monitor, sampling mid-cycle
    always @(negedge clk) begin
        logic [64:0] m;
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("one_grant", {69'b0, req0_ready && req1_ready}, 70'b0);
            if (prev_stall)
                check("resp_hold", {resp_err, resp_src, resp_tag, resp_data}, prev_snap);
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", {69'b0, resp_valid}, 70'b0);
                end else begin
                    check("resp", {resp_err, resp_src, resp_tag, resp_data}, exp_q.pop_front());
                end
                src_log.push_back(int'(resp_src));
                resp_cnt++;
            end
            if (req0_valid && req0_ready) begin
                m = model(req0_op, req0_a, req0_b);
                exp_q.push_back({m[64], 1'b0, req0_tag, m[63:0]});
                grant_log.push_back(0);
                acc_cnt++;
            end
            if (req1_valid && req1_ready) begin
                m = model(req1_op, req1_a, req1_b);
                exp_q.push_back({m[64], 1'b1, req1_tag, m[63:0]});
                grant_log.push_back(1);
                acc_cnt++;
            end
            prev_stall = resp_valid && !resp_ready;
            prev_snap  = {resp_err, resp_src, resp_tag, resp_data};
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0; req0_tag = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0; req1_tag = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle();
        step();
        step();
        rst = 0;
    endtask

    task automatic wait_resp(input int target, input int budget);
        int n = 0;
        while (resp_cnt < target && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", {69'b0, resp_cnt >= target}, 70'd1);
    endtask

    task automatic run_one(input string name, input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [3:0] tag,
                           input logic [63:0] exp_data, input logic exp_err);
        resp_ready = 1;
        req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; req0_tag = tag;
        step();
        idle();
        check({name, "_lat1"}, {69'b0, resp_valid}, 70'b0);
        step();
        check({name, "_lat2"}, {69'b0, resp_valid}, 70'd1);
        check(name, {resp_err, resp_src, resp_tag, resp_data}, {exp_err, 1'b0, tag, exp_data});
        step();
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0: return 64'h0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return {32'b0, 32'($urandom)};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    initial begin
        int base;
        int cyc;
        logic [TAG_W-1:0] held_tag;
        logic [63:0] held_data;

        resp_ready = 0;
        do_reset();
        check("rst_state", {resp_valid, resp_err, resp_src, resp_tag, resp_data}, 71'b0);

        // basic ops
        run_one("mul_3x5", 3'd0, 64'd3, 64'd5, 4'd1, 64'd15, 1'b0);
        run_one("mulh_neg", 3'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_one("mulhu", 3'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 4'd3, 64'h2, 1'b0);
        run_one("mulhsu", 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd4,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_one("mulw_zero", 3'd4, 64'h0000_0000_8000_0000, 64'd2, 4'd5, 64'h0, 1'b0);
        run_one("mulw_neg", 3'd4, 64'h4000_0000, 64'd2, 4'd6, 64'hFFFF_FFFF_8000_0000, 1'b0);

        // round-robin with both requesters contending
        do_reset();
        grant_log.delete();
        src_log.delete();
        base = resp_cnt;
        resp_ready = 1;
        req0_valid = 1; req0_op = 0; req0_a = 64'd10; req0_b = 64'd10; req0_tag = 4'd0;
        req1_valid = 1; req1_op = 0; req1_a = 64'd11; req1_b = 64'd11; req1_tag = 4'd1;
        repeat (6) step();
        idle();
        wait_resp(base + 6, 20);
        check("rr_count", 70'(grant_log.size()), 70'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            check($sformatf("rr_grant%0d", i), 70'(grant_log[i]), 70'((i + 1) % 2));
        for (int i = 0; i < 6 && i < src_log.size(); i++)
            check($sformatf("rr_src%0d", i), 70'(src_log[i]), 70'((i + 1) % 2));

        // backpressure: only two ops fit with the consumer stalled
        base = acc_cnt;
        resp_ready = 0;
        req0_valid = 1; req0_op = 0; req0_a = 64'd7; req0_b = 64'd9;
        for (int i = 0; i < 5; i++) begin
            req0_tag = 4'(acc_cnt - base);
            step();
        end
        check("bp_accepted", 70'(acc_cnt - base), 70'd2);
        check("bp_ready_low", {69'b0, req0_ready}, 70'b0);
        held_tag  = resp_tag;
        held_data = resp_data;
        check("bp_held", {resp_valid, held_tag, held_data}, {1'b1, 4'd0, 64'd63});
        base = resp_cnt;
        idle();
        resp_ready = 1;
        wait_resp(base + 2, 10);

        // reset with two ops in flight discards them
        resp_ready = 0;
        req0_valid = 1; req0_op = 3; req0_a = 64'd5; req0_b = 64'd6; req0_tag = 4'd9;
        repeat (3) step();
        rst = 1;
        idle();
        step();
        check("rst_flush", {69'b0, resp_valid}, 70'b0);
        rst = 0;
        resp_ready = 1;
        base = resp_cnt;
        repeat (4) step();
        check("rst_no_resp", {69'b0, resp_valid}, 70'b0);
        check("rst_no_cnt", 70'(resp_cnt - base), 70'd0);
        run_one("illegal_110", 3'b110, 64'd123, 64'd456, 4'd7, 64'h0, 1'b1);

        // random regression
        base = acc_cnt;
        cyc = 0;
        while (acc_cnt - base < 1000 && cyc < 20000) begin
            req0_valid = ($urandom_range(0, 9) < 7);
            req0_op = 3'($urandom_range(0, 7)); req0_a = rnd64(); req0_b = rnd64();
            req0_tag = 4'($urandom);
            req1_valid = ($urandom_range(0, 9) < 7);
            req1_op = 3'($urandom_range(0, 7)); req1_a = rnd64(); req1_b = rnd64();
            req1_tag = 4'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
            cyc++;
        end
        check("rand_accepted", {69'b0, (acc_cnt - base) >= 1000}, 70'd1);
        idle();
        resp_ready = 1;
        base = resp_cnt + exp_q.size();
        wait_resp(base, 20);
        check("rand_drained", 70'(exp_q.size()), 70'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
